// File: rtl/adc128s022_emulator.sv
// ADC128S022 converter-side SPI responder.
// Oversamples SCLK/CS/DIN with clk_50M, decodes the 3-bit channel address,
// and shifts out {4'b0, 12-bit sample} MSB first, one bit per falling SCLK.
module adc128s022_emulator #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_50M,
    input  logic                  rst_n,
    input  logic                  adc_sck,
    input  logic                  adc_cs_n,
    input  logic                  din,
    input  logic [8*DATA_W-1:0]   ch_data,
    output logic                  dout,
    output logic [2:0]            cur_ch,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int FRAME_W = DATA_W + 4;

    typedef enum logic {IDLE, FRAME} state_e;

    // Synchronizer chains; the extra top stage holds the previous synchronized
    // sample so edges are seen SYNC_STAGES+1 cycles after the pin moves.
    logic [SYNC_STAGES:0] sck_q, cs_q, din_q;

    // Input synchronizers; CS idles high so no spurious frame after reset.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= '0;
            cs_q  <= '1;
            din_q <= '0;
        end else begin
            sck_q <= {sck_q[SYNC_STAGES-1:0], adc_sck};
            cs_q  <= {cs_q[SYNC_STAGES-1:0], adc_cs_n};
            din_q <= {din_q[SYNC_STAGES-1:0], din};
        end
    end

    logic sck_rise, sck_fall, cs_rise, cs_fall, din_s;
    assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
    assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_q[SYNC_STAGES];
    assign cs_rise  = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
    assign cs_fall  = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
    assign din_s    = din_q[SYNC_STAGES-1];

    state_e               state_q, state_d;
    logic [2:0]           cur_ch_q, cur_ch_d;
    logic [2:0]           next_addr_q, next_addr_d;
    logic [2:0]           addr_cap_q, addr_cap_d;
    logic [4:0]           rcnt_q, rcnt_d;
    logic [3:0]           fcnt_q, fcnt_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    // Snapshot of the channel that the next frame will convert.
    logic [FRAME_W-1:0]   load_word;
    assign load_word = {{(FRAME_W-DATA_W){1'b0}}, ch_data[next_addr_q*DATA_W +: DATA_W]};

    // Frame state register.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_ch_q    <= '0;
            next_addr_q <= '0;
            addr_cap_q  <= '0;
            rcnt_q      <= '0;
            fcnt_q      <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            next_addr_q <= next_addr_d;
            addr_cap_q  <= addr_cap_d;
            rcnt_q      <= rcnt_d;
            fcnt_q      <= fcnt_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic; CS edges win over SCLK edges in the same cycle.
    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        next_addr_d = next_addr_q;
        addr_cap_d  = addr_cap_q;
        rcnt_d      = rcnt_q;
        fcnt_d      = fcnt_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d  = FRAME;
                    cur_ch_d = next_addr_q;
                    shift_d  = load_word;
                    rcnt_d   = '0;
                    fcnt_d   = '0;
                end
            end
            FRAME: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    // Partial frame: flag it and keep the old address.
                    if (rcnt_q != 5'd0 && rcnt_q != 5'd16) err_d = 1'b1;
                end else if (!cs_fall) begin
                    if (sck_fall) begin
                        shift_d = shift_q << 1;
                        fcnt_d  = fcnt_q + 4'd1;
                        // 16th falling edge: roll straight into the next frame.
                        if (fcnt_q == 4'd15) begin
                            cur_ch_d = next_addr_q;
                            shift_d  = load_word;
                            rcnt_d   = '0;
                        end
                    end else if (sck_rise) begin
                        if (rcnt_q != 5'd16) rcnt_d = rcnt_q + 5'd1;
                        // Rising edges 3..5 carry ADD2..ADD0.
                        if (rcnt_q >= 5'd2 && rcnt_q <= 5'd4)
                            addr_cap_d = {addr_cap_q[1:0], din_s};
                        if (rcnt_q == 5'd15) begin
                            next_addr_d = addr_cap_q;
                            done_d      = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout       = (state_q == FRAME) & shift_q[FRAME_W-1];
    assign cur_ch     = cur_ch_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_adc128s022_emulator.sv
// Directed bench: acts as the SPI controller (SCLK idles low, rise then fall
// per bit, master samples dout just before each rising edge).
module tb_adc128s022_emulator;

    localparam int H = 8;  // half SCLK period in clk_50M cycles (3.125 MHz)

    logic        clk_50M = 1'b0;
    logic        rst_n, adc_sck, adc_cs_n, din;
    logic [95:0] ch_data;
    logic        dout, frame_done, frame_err;
    logic [2:0]  cur_ch;

    int n_chk = 0, n_err = 0;
    int n_done = 0, n_ferr = 0, n_both = 0;

    adc128s022_emulator dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .adc_sck    (adc_sck),
        .adc_cs_n   (adc_cs_n),
        .din        (din),
        .ch_data    (ch_data),
        .dout       (dout),
        .cur_ch     (cur_ch),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #10 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        if (frame_done) n_done++;
        if (frame_err) n_ferr++;
        if (frame_done && frame_err) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    // Run ncyc SCLK cycles; address a0 in frame 1, a1 in frame 2.
    task automatic xfer(input logic [2:0] a0, input logic [2:0] a1, input int ncyc,
                        input bit raise, output logic [31:0] rx, output logic [2:0] ch);
        logic [2:0] a;
        int p;
        rx = '0;
        ch = '0;
        @(negedge clk_50M) adc_cs_n = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            p = k % 16;
            a = (k < 16) ? a0 : a1;
            din = (p == 2) ? a[2] : (p == 3) ? a[1] : (p == 4) ? a[0] : 1'b0;
            repeat (H) @(negedge clk_50M);
            rx = {rx[30:0], dout};
            adc_sck = 1'b1;
            repeat (H) @(negedge clk_50M);
            if (k == 0) ch = cur_ch;
            adc_sck = 1'b0;
        end
        din = 1'b0;
        repeat (H) @(negedge clk_50M);
        if (raise) begin
            adc_cs_n = 1'b1;
            repeat (2*H) @(negedge clk_50M);
        end
    endtask

    logic [31:0] rx;
    logic [2:0]  ch;
    int          d0, e0;
    logic [2:0]  addrs [4] = '{3'd1, 3'd4, 3'd3, 3'd1};
    logic [15:0] exp_v [4] = '{16'h0A5C, 16'h0123, 16'h0456, 16'h0789};
    logic [2:0]  exp_c [4] = '{3'd0, 3'd1, 3'd4, 3'd3};

    initial begin
        rst_n    = 1'b0;
        adc_sck  = 1'b0;
        adc_cs_n = 1'b1;
        din      = 1'b0;
        // ch7 .. ch0
        ch_data  = {12'h0F0, 12'h3C3, 12'hFFF, 12'h456, 12'h789, 12'h801, 12'h123, 12'hA5C};
        repeat (5) @(negedge clk_50M);
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_cur_ch", {29'd0, cur_ch}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_50M);

        // Basic read of ch0
        d0 = n_done;
        xfer(3'd0, 3'd0, 16, 1'b1, rx, ch);
        chk("basic_data", rx, 32'h0A5C);
        chk("basic_ch", {29'd0, ch}, 32'd0);
        chk("basic_done", n_done - d0, 32'd1);

        // Address pipeline: the address of frame n selects frame n+1
        for (int i = 0; i < 4; i++) begin
            xfer(addrs[i], 3'd0, 16, 1'b1, rx, ch);
            chk($sformatf("pipe_data%0d", i), rx, {16'd0, exp_v[i]});
            chk($sformatf("pipe_ch%0d", i), {29'd0, ch}, {29'd0, exp_c[i]});
        end

        // Back-to-back: 32 SCLKs under one CS, address 2 in frame 1
        d0 = n_done;
        xfer(3'd2, 3'd0, 32, 1'b1, rx, ch);
        chk("b2b_first", {16'd0, rx[31:16]}, 32'h0123);
        chk("b2b_second", {16'd0, rx[15:0]}, 32'h0801);
        chk("b2b_done", n_done - d0, 32'd2);

        // Abort: select ch4, then a partial frame carrying address 5
        xfer(3'd4, 3'd0, 16, 1'b1, rx, ch);
        chk("pre_abort_data", rx, 32'h0A5C);
        d0 = n_done;
        e0 = n_ferr;
        xfer(3'd5, 3'd0, 8, 1'b1, rx, ch);
        chk("abort_err", n_ferr - e0, 32'd1);
        chk("abort_done", n_done - d0, 32'd0);
        xfer(3'd1, 3'd0, 16, 1'b1, rx, ch);
        chk("post_abort_data", rx, 32'h0456);
        chk("post_abort_ch", {29'd0, ch}, 32'd4);

        // Reset after the 10th falling edge of a ch1 frame
        e0 = n_ferr;
        xfer(3'd0, 3'd0, 10, 1'b0, rx, ch);
        chk("mid_ch", {29'd0, cur_ch}, 32'd1);
        chk("mid_dout", {31'd0, dout}, 32'd1);  // bit 5 of 0x123
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50M);
        chk("inrst_dout", {31'd0, dout}, 32'd0);
        chk("inrst_ch", {29'd0, cur_ch}, 32'd0);
        adc_cs_n = 1'b1;
        repeat (4) @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (8) @(negedge clk_50M);
        xfer(3'd3, 3'd0, 16, 1'b1, rx, ch);
        chk("post_rst_data", rx, 32'h0A5C);
        chk("post_rst_ch", {29'd0, ch}, 32'd0);
        chk("post_rst_err", n_ferr - e0, 32'd0);

        chk("done_total", n_done, 32'd10);
        chk("done_err_overlap", n_both, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
